// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive path: word width, FSM state
// encoding and the idle levels the input synchronisers reset to.
package spi_pkg;

    localparam int SPI_WORD_W = 16;

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        IDLE  = 2'd1,
        SHIFT = 2'd2
    } spi_rx_state_t;

    // Idle bus levels: CS deasserted, clock low, data low.
    localparam logic CS_RST   = 1'b1;
    localparam logic SCLK_RST = 1'b0;
    localparam logic DATA_RST = 1'b0;

endpackage

// File: rtl/spi_rx_fifo.sv
// Small synchronous FIFO for received words. Pointers carry one extra wrap
// bit so full and empty are distinguished without a separate counter.
// A push into a full FIFO succeeds when a pop happens on the same cycle.
module spi_rx_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("spi_rx_fifo: DEPTH must be a power of 2 and at least 2");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q;
    logic [AW:0]      rd_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = mem_q[rd_q[AW-1:0]];

    // Storage and pointer update; a same-cycle push into a full FIFO reuses
    // the slot being popped, which is read combinationally before it moves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_q[AW-1:0]] <= data_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_slave_rx.sv
// SPI receive stage: synchronises CS/SCLK/DATA into clk, deserialises
// MSB-first words and offers them on a valid/ready port.
// Build option: define SPI_RX_FIFO_EN to replace the single holding
// register with a FIFO_DEPTH-entry FIFO (spi_rx_fifo).
//
// state | meaning
// ARM   | after reset; wait for the bus to be seen idle (CS high)
// IDLE  | CS high, waiting for a frame to start
// SHIFT | CS low, shifting one bit per SCLK rise
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = SPI_WORD_W,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          spi_CS,
    input  logic                          spi_sclk,
    input  logic                          spiData,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    input  logic                          clr_overrun,
    output logic [$clog2(DATA_WIDTH):0]   bit_count
);

    localparam int CW    = $clog2(DATA_WIDTH) + 1;
    localparam int ARM_W = $clog2(SYNC_STAGES + 1);
    localparam logic [2:0] SYNC_RST = {DATA_RST, SCLK_RST, CS_RST};

    if (SYNC_STAGES < 1) begin : g_bad_sync
        $error("spi_slave_rx: SYNC_STAGES must be at least 1");
    end
    if (FIFO_DEPTH < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo
        $error("spi_slave_rx: FIFO_DEPTH must be a power of 2");
    end

    // {data, sclk, cs} travel together so all three see the same delay.
    logic [2:0]            sync_q [SYNC_STAGES];
    logic                  cs_s;
    logic                  sclk_s;
    logic                  data_s;
    logic                  sclk_prev_q;
    logic                  sclk_rise;
    logic [ARM_W-1:0]      arm_cnt_q;
    spi_rx_state_t         state_q;
    spi_rx_state_t         state_d;
    logic                  shift_en;
    logic                  word_done;
    logic                  abort;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [CW-1:0]         bit_cnt_q;
    logic                  push_q;
    logic                  frame_err_q;
    logic                  overrun_q;
    logic                  drop;

    assign cs_s      = sync_q[SYNC_STAGES-1][0];
    assign sclk_s    = sync_q[SYNC_STAGES-1][1];
    assign data_s    = sync_q[SYNC_STAGES-1][2];
    assign sclk_rise = sclk_s & ~sclk_prev_q;

    // Input synchroniser chains, reset to the idle bus levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= SYNC_RST;
            end
            sclk_prev_q <= SCLK_RST;
        end else begin
            sync_q[0] <= {spiData, spi_sclk, spi_CS};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            sclk_prev_q <= sclk_s;
        end
    end

    // Down-counter that expires once the synchronisers hold real pin values;
    // until then CS=1 is only the reset fill and must not release ARM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            arm_cnt_q <= ARM_W'(SYNC_STAGES);
        end else if (arm_cnt_q != '0) begin
            arm_cnt_q <= arm_cnt_q - 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARM;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ARM:     if (arm_cnt_q == '0 && cs_s) state_d = IDLE;
            IDLE:    if (!cs_s)                   state_d = SHIFT;
            SHIFT:   if (cs_s)                    state_d = IDLE;
            default:                              state_d = ARM;
        endcase
    end

    // FSM outputs; a CS rise masks an SCLK rise seen on the same cycle.
    always_comb begin
        shift_en  = 1'b0;
        word_done = 1'b0;
        abort     = 1'b0;
        if (state_q == SHIFT) begin
            if (cs_s) begin
                abort = (bit_cnt_q != '0);
            end else if (sclk_rise) begin
                shift_en  = 1'b1;
                word_done = (bit_cnt_q == CW'(DATA_WIDTH - 1));
            end
        end
    end

    // Shift register, bit counter, and the registered push/error strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            push_q      <= word_done;
            frame_err_q <= abort;
            if (shift_en) begin
                shift_q <= {shift_q[DATA_WIDTH-2:0], data_s};
            end
            if (state_q != SHIFT || cs_s || word_done) begin
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end
    end

`ifdef SPI_RX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    spi_rx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_q),
        .data_i  (shift_q),
        .pop_i   (rx_ready),
        .data_o  (rx_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign rx_valid = ~fifo_empty;
    assign drop     = push_q & fifo_full & ~rx_ready;
`else
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  hold_valid_q;

    assign drop = push_q & hold_valid_q & ~rx_ready;

    // Single-entry holding register; a push is taken when empty or popping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else if (push_q && (!hold_valid_q || rx_ready)) begin
            hold_q       <= shift_q;
            hold_valid_q <= 1'b1;
        end else if (hold_valid_q && rx_ready) begin
            hold_valid_q <= 1'b0;
        end
    end

    assign rx_data  = hold_q;
    assign rx_valid = hold_valid_q;
`endif

    // Sticky overrun; a drop on the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (clr_overrun) begin
            overrun_q <= 1'b0;
        end
    end

    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign bit_count = bit_cnt_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx (default parameters).
module tb_spi_slave_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_CS;
    logic        spi_sclk;
    logic        spiData;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        frame_err;
    logic        overrun;
    logic        clr_overrun;
    logic [4:0]  bit_count;

    int n_pass  = 0;
    int n_total = 0;
    int ferr_cnt = 0;
    logic [15:0] popped[$];

    typedef struct {
        logic [15:0] word;
        int          nbits;
        logic        exp_valid;
        logic [15:0] exp_data;
        int          exp_ferr;
    } vec_t;

    vec_t vecs[8];

    spi_slave_rx dut (
        .clk         (clk),
        .reset       (reset),
        .spi_CS      (spi_CS),
        .spi_sclk    (spi_sclk),
        .spiData     (spiData),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .frame_err   (frame_err),
        .overrun     (overrun),
        .clr_overrun (clr_overrun),
        .bit_count   (bit_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err) ferr_cnt++;
        if (rx_valid && rx_ready) popped.push_back(rx_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_range(input logic [15:0] word, input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            spiData  = word[15-i];
            spi_sclk = 1'b0;
            tick(1);
            spi_sclk = 1'b1;
            tick(1);
        end
    endtask

    task automatic frame(input logic [15:0] word, input int nbits);
        spi_CS = 1'b0;
        tick(4);
        send_range(word, 0, nbits);
        spi_sclk = 1'b0;
        tick(4);
        spi_CS = 1'b1;
        tick(6);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int fbase;
        int qbase;
        logic [15:0] w;

        vecs[0] = '{16'hA5C3, 16, 1'b1, 16'hA5C3, 0};
        vecs[1] = '{16'h1234, 16, 1'b1, 16'h1234, 0};
        vecs[2] = '{16'hFFFF, 16, 1'b1, 16'hFFFF, 0};
        vecs[3] = '{16'h0000, 16, 1'b1, 16'h0000, 0};
        vecs[4] = '{16'h8001, 16, 1'b1, 16'h8001, 0};
        vecs[5] = '{16'h00FF,  7, 1'b0, 16'h0000, 1};
        vecs[6] = '{16'hBEEF,  1, 1'b0, 16'h0000, 1};
        vecs[7] = '{16'h7FFE, 15, 1'b0, 16'h0000, 1};

        reset = 1'b1; spi_CS = 1'b1; spi_sclk = 1'b0; spiData = 1'b0;
        rx_ready = 1'b0; clr_overrun = 1'b0;
        tick(3);
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_bitcount", bit_count, 0);
        reset = 1'b0;
        tick(5);

        // Latency from last SCLK rise at the pin to rx_valid.
        fbase = ferr_cnt;
        w = 16'hA5C3;
        spi_CS = 1'b0;
        tick(4);
        send_range(w, 0, 15);
        spiData  = w[0];
        spi_sclk = 1'b0;
        tick(1);
        spi_sclk = 1'b1;
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (rx_valid) begin
                lat = c;
                break;
            end
        end
        check("latency", lat, 4);
        spi_sclk = 1'b0;
        tick(2);
        spi_CS = 1'b1;
        tick(6);
        check("lat_data", rx_data, 16'hA5C3);
        check("lat_ferr", ferr_cnt - fbase, 0);
        check("lat_overrun", overrun, 0);
        pop_one();
        check("lat_popped", rx_valid, 0);

        // Table of single frames, full and truncated.
        for (int v = 0; v < 8; v++) begin
            fbase = ferr_cnt;
            frame(vecs[v].word, vecs[v].nbits);
            check($sformatf("vec%0d_valid", v), rx_valid, vecs[v].exp_valid);
            if (vecs[v].exp_valid) check($sformatf("vec%0d_data", v), rx_data, vecs[v].exp_data);
            check($sformatf("vec%0d_ferr", v), ferr_cnt - fbase, vecs[v].exp_ferr);
            check($sformatf("vec%0d_overrun", v), overrun, 0);
            if (rx_valid) pop_one();
            check($sformatf("vec%0d_empty", v), rx_valid, 0);
        end

        // Bit counter mid-word, then the frame completes.
        spi_CS = 1'b0;
        tick(4);
        send_range(16'h1234, 0, 5);
        spi_sclk = 1'b0;
        tick(3);
        check("bc_mid", bit_count, 5);
        send_range(16'h1234, 5, 16);
        spi_sclk = 1'b0;
        tick(4);
        spi_CS = 1'b1;
        tick(6);
        check("bc_frame_data", rx_data, 16'h1234);
        check("bc_frame_valid", rx_valid, 1);
        pop_one();

        // Two back-to-back words in one CS window, consumer always ready.
        qbase = popped.size();
        rx_ready = 1'b1;
        spi_CS = 1'b0;
        tick(4);
        send_range(16'h0001, 0, 16);
        spi_sclk = 1'b0;
        tick(2);
        check("b2b_bc_between", bit_count, 0);
        send_range(16'h8000, 0, 16);
        spi_sclk = 1'b0;
        tick(4);
        spi_CS = 1'b1;
        tick(6);
        rx_ready = 1'b0;
        check("b2b_count", popped.size() - qbase, 2);
        if (popped.size() >= qbase + 2) begin
            check("b2b_word0", popped[qbase], 16'h0001);
            check("b2b_word1", popped[qbase+1], 16'h8000);
        end

        // Three words with a stalled consumer.
        spi_CS = 1'b0;
        tick(4);
        send_range(16'h1111, 0, 16);
        send_range(16'h2222, 0, 16);
        send_range(16'h3333, 0, 16);
        spi_sclk = 1'b0;
        tick(4);
        spi_CS = 1'b1;
        tick(6);
        check("stall_valid", rx_valid, 1);
        check("stall_data", rx_data, 16'h1111);
`ifdef SPI_RX_FIFO_EN
        check("stall_overrun", overrun, 0);
        pop_one();
        check("stall_data1", rx_data, 16'h2222);
        pop_one();
        check("stall_data2", rx_data, 16'h3333);
        pop_one();
`else
        check("stall_overrun", overrun, 1);
        pop_one();
`endif
        check("stall_drained", rx_valid, 0);
        clr_overrun = 1'b1;
        tick(1);
        clr_overrun = 1'b0;
        check("clr_overrun", overrun, 0);

        // Push arriving while full with a pop on the same cycle.
        qbase = popped.size();
        spi_CS = 1'b0;
        tick(4);
        send_range(16'h5A5A, 0, 16);
        spi_sclk = 1'b0;
        tick(4);
        w = 16'hC3C3;
        send_range(w, 0, 15);
        spiData  = w[0];
        spi_sclk = 1'b0;
        tick(1);
        spi_sclk = 1'b1;
        repeat (3) @(posedge clk);
        #1 rx_ready = 1'b1;
        @(negedge clk);
        check("pp_head_before", rx_data, 16'h5A5A);
        check("pp_valid_before", rx_valid, 1);
        @(posedge clk);
        #1 rx_ready = 1'b0;
        @(negedge clk);
        check("pp_head_after", rx_data, 16'hC3C3);
        check("pp_valid_after", rx_valid, 1);
        check("pp_overrun", overrun, 0);
        spi_sclk = 1'b0;
        tick(2);
        spi_CS = 1'b1;
        tick(6);
        check("pp_pop_count", popped.size() - qbase, 1);
        if (popped.size() >= qbase + 1) check("pp_popped_word", popped[qbase], 16'h5A5A);
        pop_one();
        check("pp_drained", rx_valid, 0);

        // Reset in the middle of a frame, released with CS still low.
        fbase = ferr_cnt;
        spi_CS = 1'b0;
        tick(4);
        send_range(16'hF0F0, 0, 5);
        reset = 1'b1;
        tick(2);
        check("mrst_valid", rx_valid, 0);
        check("mrst_bc", bit_count, 0);
        reset = 1'b0;
        send_range(16'hF0F0, 5, 16);
        spi_sclk = 1'b0;
        tick(4);
        check("mrst_no_word", rx_valid, 0);
        check("mrst_bc_idle", bit_count, 0);
        spi_CS = 1'b1;
        tick(6);
        check("mrst_no_ferr", ferr_cnt - fbase, 0);
        check("mrst_still_empty", rx_valid, 0);
        frame(16'hBEEF, 16);
        check("mrst_next_valid", rx_valid, 1);
        check("mrst_next_data", rx_data, 16'hBEEF);
        pop_one();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

Receive-side stage downstream of the SPI master transmitter. Samples the serial stream (chip-select, serial clock, data) in the system clock domain, deserialises MSB-first 16-bit words, and presents each completed word on a valid/ready output port. Flags truncated frames and words dropped because the consumer stalled.

## Interface
Parameters:
- DATA_WIDTH, 16, bits per word; bit counter width is $clog2(DATA_WIDTH)+1.
- SYNC_STAGES, 2, flops per input synchroniser; minimum 1.
- FIFO_DEPTH, 4, output FIFO entries, power of 2; used only when SPI_RX_FIFO_EN is defined.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- spi_CS  in  1  chip select, active low.
- spi_sclk  in  1  serial clock; data is sampled on its rising edge.
- spiData  in  1  serial data, MSB first.
- rx_data  out  DATA_WIDTH  received word; valid while rx_valid=1.
- rx_valid  out  1  a word is available.
- rx_ready  in  1  consumer accepts the word when rx_valid & rx_ready.
- frame_err  out  1  one-cycle pulse when CS rises mid-word.
- overrun  out  1  sticky flag; a completed word was dropped.
- clr_overrun  in  1  synchronous clear of overrun.
- bit_count  out  $clog2(DATA_WIDTH)+1  bits captured in the current word.

## Operation
- Each of spi_CS, spi_sclk and spiData passes through its own SYNC_STAGES flop chain. Reset values: CS=1, sclk=0, data=0.
- sclk rise = synchronised sclk is 1 and was 0 on the previous cycle. All three inputs are delayed equally, so data is sampled on the same cycle the rise is detected.
- FSM states:
  - ARM: after reset. Waits for synchronised CS=1, then goes to IDLE. This stops a frame already in progress at reset from being captured.
  - IDLE: CS=1. Goes to SHIFT when synchronised CS=0.
  - SHIFT: on each sclk rise, shift_reg <= {shift_reg[DATA_WIDTH-2:0], data} and bit_count increments.
- Word completion: when bit_count reaches DATA_WIDTH-1 and a rise arrives, the completed word is pushed and bit_count returns to 0. The FSM stays in SHIFT, so back-to-back words inside one CS-low window are supported.
- CS rising in SHIFT:
  - bit_count=0: go to IDLE, no flag.
  - bit_count≠0: pulse frame_err for one cycle, discard the partial word, clear bit_count, go to IDLE.
- If a CS rise and a sclk rise are detected on the same cycle, CS wins and the sclk rise is ignored.
- Output buffer without the macro: a single holding register.
  - Push when empty: the register loads and rx_valid=1.
  - Push while full with no pop that cycle: the new word is dropped, the held word is kept, and overrun is set.
  - Push and pop on the same cycle: the new word is accepted and rx_valid stays 1.
- overrun: set by a dropped push; cleared by reset or clr_overrun. If set and clear occur on the same cycle, set wins.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, bit_count=0, FSM=ARM.
- A reset mid-frame discards all state, including the partial word and any buffered words.

## Timing
- Input latency: SYNC_STAGES cycles from a pin change to FSM visibility.
- Latency from the last-bit sclk rise at the pin to rx_valid=1 is SYNC_STAGES+2 cycles (synchroniser, edge detect/shift, push).
- The minimum sclk high time and low time is 1 clk each; the master's 2-cycle sclk period is supported.
- The minimum CS-high gap between frames is 1 clk; it survives the synchronisers.
- rx_data and rx_valid are registered outputs. rx_ready is combinationally used only for the pop decision.

## Configuration
- SPI_RX_FIFO_EN defined: the holding register is replaced by a FIFO_DEPTH-entry FIFO.
  - rx_valid = not empty; rx_data = head entry.
  - Push when full with no pop that cycle: the word is dropped and overrun is set.
  - Push and pop on the same cycle when full: the push succeeds.
  - Read and write pointers have one extra wrap bit.
- SPI_RX_FIFO_EN undefined: single holding register as in Operation. Identical to the FIFO behaviour with FIFO_DEPTH=1.

## Structure
- Shared package spi_pkg:
  - SPI_WORD_W=16.
  - FSM state typedef spi_rx_state_t with values ARM, IDLE, SHIFT.
  - Reset values of the synchronised lines.
- One sub-module, spi_rx_fifo: synchronous FIFO with push/pop/full/empty.
  - Instantiated only under SPI_RX_FIFO_EN; otherwise the holding register is inline.
- Synchronisers are inline generate loops; no separate module.

## Test plan
- Reset released with CS high, then frame 0xA5C3 sent at a 2-clk sclk period: rx_valid rises SYNC_STAGES+2 cycles after the 16th rise, rx_data=0xA5C3, frame_err=0, overrun=0.
- Two words 0x0001 and 0x8000 in one CS-low window with rx_ready=1: two consecutive valid beats with the same values, bit_count back at 0 between words.
- CS raised after 7 bits: frame_err pulses for exactly 1 cycle, no rx_valid. The next full frame 0x1234 is received correctly.
- rx_ready=0 and three words sent:
  - Without the macro: rx_data=first word, overrun=1.
  - With the macro and FIFO_DEPTH=4: all three are queued, overrun=0.
  - Then clr_overrun pulsed: overrun=0.
- Reset asserted after 5 bits, released with CS still low: no word is produced until CS goes high and a new frame starts. The next frame 0xBEEF is received intact.
- rx_ready=1 with a push arriving while full, and a pop on the same cycle: no overrun, word order preserved.
